turn_ctrl_b: RTL and testbench

TURN_CTRL_B -- requirements
Module: turn_ctrl_b

---
 rtl/turn_ctrl_b.sv | 213 +++++++++++++++++++++
 tb/tb_turn_ctrl_b.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_ctrl_b.sv
// ---------------------------------------------------------------------------
// turn_ctrl_b -- turn sequencer for the player-B side of the battleship game.
//
// Buttons are synchronised and edge-detected into single-cycle pulses. A
// Moore FSM then steps through placing the fleet, aiming, firing, defending
// against the opponent's attack, and checking survival. All outputs are
// decoded from the state register only.
//
// Optional build: define TURN_CTRL_DEBOUNCE_EN to insert a per-button
// debounce counter (DEB_CYCLES consecutive equal samples) between the
// synchroniser and the edge detector. Without it, the synchroniser feeds the
// edge detector directly and a press reaches the FSM state on the 4th edge.
//
// Parameters
//   DEB_CYCLES  stable samples required before a new button level is taken
//               (debounce build only)
// Ports
//   clk        system clock, all flops on the rising edge
//   clr_n      asynchronous active-low reset
//   btn_place  raw button: commit ship layout
//   btn_fire   raw button: commit attack
//   btn_new    raw button: restart game (overrides every transition)
//   ok_in      opponent's new attack accepted
//   liv_b      own fleet alive
//   liv_a      opponent fleet alive
//   ldr1b      load pulse, ship register (LOAD and HIT)
//   ldr2b      load pulse, attack register (FIRE)
//   clr        synchronous clear pulse to datapath registers (CLEAR)
//   st         ship register source: 0 = switches, 1 = surviving ships
//   disp_b     status display word select
//   state_dbg  current FSM state, for observation only
//              0 IDLE 1 CLEAR 2 PLACE 3 LOAD 4 AIM 5 FIRE 6 DEFEND
//              7 HIT 8 CHECK 9 WIN 10 LOSE
// ---------------------------------------------------------------------------
module turn_ctrl_b #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_place,
  input  logic       btn_fire,
  input  logic       btn_new,
  input  logic       ok_in,
  input  logic       liv_b,
  input  logic       liv_a,
  output logic       ldr1b,
  output logic       ldr2b,
  output logic       clr,
  output logic       st,
  output logic [2:0] disp_b,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLEAR  = 4'd1;
  localparam logic [3:0] S_PLACE  = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_AIM    = 4'd4;
  localparam logic [3:0] S_FIRE   = 4'd5;
  localparam logic [3:0] S_DEFEND = 4'd6;
  localparam logic [3:0] S_HIT    = 4'd7;
  localparam logic [3:0] S_CHECK  = 4'd8;
  localparam logic [3:0] S_WIN    = 4'd9;
  localparam logic [3:0] S_LOSE   = 4'd10;

  // The debounce compare uses DEB_CYCLES-1; zero or negative is meaningless.
  if (DEB_CYCLES < 1) begin : g_deb_range
    $error("turn_ctrl_b: DEB_CYCLES must be at least 1");
  end

  // Button bit order used throughout: [0] place, [1] fire, [2] new.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] filt;
  logic [2:0] filt_d;
  logic [2:0] pulse;

  assign btn_raw = {btn_new, btn_fire, btn_place};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef TURN_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] deb_cnt [3];
  logic [2:0]    deb_lvl;

  // A sample that differs from the accepted level counts towards a change;
  // any sample equal to the accepted level restarts the count, so only an
  // unbroken run of DEB_CYCLES new-level samples is accepted.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      deb_lvl <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filt = deb_lvl;
`else
  assign filt = sync2;
`endif

  // Registered rising-edge detector: the pulse flop gives a clean 1-cycle
  // pulse and fixes the press-to-state latency at 4 edges without debounce.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      filt_d <= '0;
      pulse  <= '0;
    end else begin
      filt_d <= filt;
      pulse  <= filt & ~filt_d;
    end
  end

  logic place_p;
  logic fire_p;
  logic new_p;

  assign place_p = pulse[0];
  assign fire_p  = pulse[1];
  assign new_p   = pulse[2];

  logic [3:0] state;
  logic [3:0] state_nxt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Restart beats everything; inside AIM/DEFEND a dead opponent fleet wins
  // over a simultaneous fire or accepted attack.
  always_comb begin
    state_nxt = state;
    if (new_p) begin
      state_nxt = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_CLEAR;
        S_CLEAR:  state_nxt = S_PLACE;
        S_PLACE:  if (place_p) state_nxt = S_LOAD;
        S_LOAD:   state_nxt = S_AIM;
        S_AIM: begin
          if (!liv_a)      state_nxt = S_WIN;
          else if (fire_p) state_nxt = S_FIRE;
        end
        S_FIRE:   state_nxt = S_DEFEND;
        S_DEFEND: begin
          if (!liv_a)     state_nxt = S_WIN;
          else if (ok_in) state_nxt = S_HIT;
        end
        S_HIT:    state_nxt = S_CHECK;
        S_CHECK:  state_nxt = liv_b ? S_AIM : S_LOSE;
        S_WIN:    state_nxt = S_WIN;
        S_LOSE:   state_nxt = S_LOSE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ldr1b  = 1'b0;
    ldr2b  = 1'b0;
    clr    = 1'b0;
    st     = 1'b0;
    disp_b = 3'd0;
    case (state)
      S_CLEAR:  clr = 1'b1;
      S_LOAD:   ldr1b = 1'b1;
      S_AIM:    disp_b = 3'd1;
      S_FIRE: begin
        ldr2b  = 1'b1;
        disp_b = 3'd1;
      end
      S_DEFEND: disp_b = 3'd2;
      S_HIT: begin
        ldr1b  = 1'b1;
        st     = 1'b1;
        disp_b = 3'd2;
      end
      S_CHECK: begin
        st     = 1'b1;
        disp_b = 3'd2;
      end
      S_WIN:    disp_b = 3'd3;
      S_LOSE:   disp_b = 3'd4;
      default:  disp_b = 3'd0;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_turn_ctrl_b.sv
// ---------------------------------------------------------------------------
// tb_turn_ctrl_b -- directed bench for turn_ctrl_b. Every load/clear pulse
// the DUT emits is matched against an expected queue filled as stimulus is
// driven; state and output words are also checked at fixed points.
// Output word layout: {clr, ldr1b, ldr2b, st, disp_b[2:0]}.
// ---------------------------------------------------------------------------
module tb_turn_ctrl_b;

  localparam int DEB = 4;
`ifdef TURN_CTRL_DEBOUNCE_EN
  localparam int LAT = 4 + DEB;
`else
  localparam int LAT = 4;
`endif

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLEAR  = 4'd1;
  localparam logic [3:0] S_PLACE  = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_AIM    = 4'd4;
  localparam logic [3:0] S_FIRE   = 4'd5;
  localparam logic [3:0] S_DEFEND = 4'd6;
  localparam logic [3:0] S_HIT    = 4'd7;
  localparam logic [3:0] S_CHECK  = 4'd8;
  localparam logic [3:0] S_WIN    = 4'd9;
  localparam logic [3:0] S_LOSE   = 4'd10;

  localparam logic [6:0] O_ZERO  = 7'b1_0_0_0_000 ^ 7'b1_0_0_0_000;
  localparam logic [6:0] O_CLR   = 7'b1_0_0_0_000;
  localparam logic [6:0] O_LOAD  = 7'b0_1_0_0_000;
  localparam logic [6:0] O_AIM   = 7'b0_0_0_0_001;
  localparam logic [6:0] O_FIRE  = 7'b0_0_1_0_001;
  localparam logic [6:0] O_DEF   = 7'b0_0_0_0_010;
  localparam logic [6:0] O_HIT   = 7'b0_1_0_1_010;
  localparam logic [6:0] O_CHECK = 7'b0_0_0_1_010;
  localparam logic [6:0] O_WIN   = 7'b0_0_0_0_011;
  localparam logic [6:0] O_LOSE  = 7'b0_0_0_0_100;

  localparam int B_PLACE = 0;
  localparam int B_FIRE  = 1;
  localparam int B_NEW   = 2;

  logic       clk;
  logic       clr_n;
  logic       btn_place;
  logic       btn_fire;
  logic       btn_new;
  logic       ok_in;
  logic       liv_b;
  logic       liv_a;
  logic       ldr1b;
  logic       ldr2b;
  logic       clr;
  logic       st;
  logic [2:0] disp_b;
  logic [3:0] state_dbg;
  logic [6:0] out_w;

  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q[$];

  turn_ctrl_b #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .btn_place (btn_place),
    .btn_fire  (btn_fire),
    .btn_new   (btn_new),
    .ok_in     (ok_in),
    .liv_b     (liv_b),
    .liv_a     (liv_a),
    .ldr1b     (ldr1b),
    .ldr2b     (ldr2b),
    .clr       (clr),
    .st        (st),
    .disp_b    (disp_b),
    .state_dbg (state_dbg)
  );

  assign out_w = {clr, ldr1b, ldr2b, st, disp_b};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checkers
  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp);
    checks++;
    assert (state_dbg === exp) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, exp);
    end
  endtask

  // scoreboard: every pulse cycle must match the next queued expectation
  always @(negedge clk) begin
    if (clr | ldr1b | ldr2b) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed=%b expected=none", out_w);
      end
      if (exp_q.size() > 0) chk("sb_pulse", out_w, exp_q.pop_front());
    end
  end

  // drivers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_PLACE: btn_place = v;
      B_FIRE:  btn_fire  = v;
      default: btn_new   = v;
    endcase
  endtask

  // Hold a button for 'hold' cycles, check the state just before and at the
  // expected transition edge, then release and let the filter settle.
  task automatic press(input int which, input int hold, input logic [3:0] s_before,
                       input logic [3:0] s_at, input logic [6:0] o_at, input string tag);
    set_btn(which, 1'b1);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == LAT - 1) chk_state({tag, "_pre"}, s_before);
      if (i == LAT) begin
        chk_state({tag, "_at"}, s_at);
        chk({tag, "_out"}, out_w, o_at);
      end
    end
    set_btn(which, 1'b0);
    tick(LAT + 1);
  endtask

  initial begin
    clr_n     = 1'b0;
    btn_place = 1'b0;
    btn_fire  = 1'b0;
    btn_new   = 1'b0;
    ok_in     = 1'b0;
    liv_a     = 1'b1;
    liv_b     = 1'b1;

    // reset state and release
    @(negedge clk);
    chk("rst_out", out_w, O_ZERO);
    chk_state("rst_state", S_IDLE);
    exp_q.push_back(O_CLR);
    clr_n = 1'b1;
    @(negedge clk);
    chk("boot_clr", out_w, O_CLR);
    chk_state("boot_clear", S_CLEAR);
    @(negedge clk);
    chk("boot_place_out", out_w, O_ZERO);
    chk_state("boot_place", S_PLACE);
    @(negedge clk);
    chk_state("boot_place_hold", S_PLACE);

    // fire and ok_in are ignored while placing
    ok_in = 1'b1;
    set_btn(B_FIRE, 1'b1);
    tick(2);
    ok_in = 1'b0;
    set_btn(B_FIRE, 1'b0);
    tick(LAT + 2);
    chk_state("place_ignore", S_PLACE);

    // place held 10 cycles: one LOAD pulse, then AIM
    exp_q.push_back(O_LOAD);
    press(B_PLACE, 10, S_PLACE, S_LOAD, O_LOAD, "place");
    chk_state("aim1", S_AIM);
    chk("aim1_out", out_w, O_AIM);

    // ok_in ignored while aiming
    ok_in = 1'b1;
    tick(2);
    ok_in = 1'b0;
    chk_state("aim_ignore_ok", S_AIM);

`ifdef TURN_CTRL_DEBOUNCE_EN
    // chattering fire button never settles long enough
    for (int k = 0; k < 4; k++) begin
      set_btn(B_FIRE, 1'b1);
      tick(2);
      set_btn(B_FIRE, 1'b0);
      tick(2);
    end
    tick(LAT + 2);
    chk_state("deb_chatter", S_AIM);
`endif

    // fire held 8 cycles: one FIRE pulse, then DEFEND
    exp_q.push_back(O_FIRE);
    press(B_FIRE, 8, S_AIM, S_FIRE, O_FIRE, "fire1");
    chk_state("defend1", S_DEFEND);
    chk("defend1_out", out_w, O_DEF);

    // attack accepted, survive, back to AIM
    exp_q.push_back(O_HIT);
    ok_in = 1'b1;
    @(negedge clk);
    chk_state("hit1", S_HIT);
    chk("hit1_out", out_w, O_HIT);
    ok_in = 1'b0;
    @(negedge clk);
    chk_state("check1", S_CHECK);
    chk("check1_out", out_w, O_CHECK);
    @(negedge clk);
    chk_state("aim2", S_AIM);
    chk("aim2_out", out_w, O_AIM);

    // second round, own fleet sunk -> LOSE
    exp_q.push_back(O_FIRE);
    press(B_FIRE, 8, S_AIM, S_FIRE, O_FIRE, "fire2");
    liv_b = 1'b0;
    exp_q.push_back(O_HIT);
    ok_in = 1'b1;
    @(negedge clk);
    chk_state("hit2", S_HIT);
    ok_in = 1'b0;
    @(negedge clk);
    chk_state("check2", S_CHECK);
    @(negedge clk);
    chk_state("lose", S_LOSE);
    chk("lose_out", out_w, O_LOSE);
    press(B_FIRE, 8, S_LOSE, S_LOSE, O_LOSE, "lose_hold");

    // restart from LOSE
    liv_b = 1'b1;
    exp_q.push_back(O_CLR);
    press(B_NEW, 8, S_LOSE, S_CLEAR, O_CLR, "new1");
    chk_state("new1_place", S_PLACE);
    exp_q.push_back(O_LOAD);
    press(B_PLACE, 10, S_PLACE, S_LOAD, O_LOAD, "place2");
    exp_q.push_back(O_FIRE);
    press(B_FIRE, 8, S_AIM, S_FIRE, O_FIRE, "fire3");
    chk_state("defend3", S_DEFEND);

    // ok_in and dead opponent together in DEFEND: WIN, no HIT load
    ok_in = 1'b1;
    liv_a = 1'b0;
    @(negedge clk);
    chk_state("win_defend", S_WIN);
    chk("win_defend_out", out_w, O_WIN);
    ok_in = 1'b0;
    tick(3);
    chk_state("win_hold", S_WIN);

    // restart, then WIN from AIM beats a simultaneous fire pulse
    liv_a = 1'b1;
    exp_q.push_back(O_CLR);
    press(B_NEW, 8, S_WIN, S_CLEAR, O_CLR, "new2");
    exp_q.push_back(O_LOAD);
    press(B_PLACE, 10, S_PLACE, S_LOAD, O_LOAD, "place3");
    set_btn(B_FIRE, 1'b1);
    tick(LAT - 1);
    chk_state("win_aim_pre", S_AIM);
    liv_a = 1'b0;
    @(negedge clk);
    chk_state("win_aim", S_WIN);
    chk("win_aim_out", out_w, O_WIN);
    tick(3);
    set_btn(B_FIRE, 1'b0);
    tick(LAT + 1);
    liv_a = 1'b1;

    // reset in the middle of HIT
    exp_q.push_back(O_CLR);
    press(B_NEW, 8, S_WIN, S_CLEAR, O_CLR, "new3");
    exp_q.push_back(O_LOAD);
    press(B_PLACE, 10, S_PLACE, S_LOAD, O_LOAD, "place4");
    exp_q.push_back(O_FIRE);
    press(B_FIRE, 8, S_AIM, S_FIRE, O_FIRE, "fire4");
    exp_q.push_back(O_HIT);
    ok_in = 1'b1;
    @(negedge clk);
    chk_state("hit4", S_HIT);
    #2;
    clr_n = 1'b0;
    ok_in = 1'b0;
    #1;
    chk("async_rst_out", out_w, O_ZERO);
    chk_state("async_rst_state", S_IDLE);
    @(negedge clk);
    chk("rst_hold_out", out_w, O_ZERO);
    exp_q.push_back(O_CLR);
    clr_n = 1'b1;
    @(negedge clk);
    chk("reboot_clr", out_w, O_CLR);
    @(negedge clk);
    chk_state("reboot_place", S_PLACE);
    tick(2);

    // every queued pulse must have been seen
    chk("sb_empty", 7'(exp_q.size()), O_ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
